// File: rtl/pipe_pkg.sv
// Shared types and field widths for the inter-stage pipeline registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    // Occupancy of a pipeline stage: nothing held, main entry held, or main plus skid held.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_e;

    // Control bundle packing, low to high: EX fields, then MEM fields, then WB fields.
    localparam int EX_CTRL_W   = 9;
    localparam int MEM_CTRL_W  = 5;
    localparam int WB_CTRL_W   = 11;
    localparam int PIPE_CTRL_W = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;

    // Payload packing: instr, pc, rs1, rs2 and imm, each 32 bits.
    localparam int FIELD_W     = 32;
    localparam int PIPE_DATA_W = 5 * FIELD_W;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
// Latency: count reflects an event on the cycle after it occurs.
// Backpressure: none; it only observes events.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});
    assign o_count  = r_count;

    // Count qualifying cycles, stick at all-ones, and let clear take priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying payload and control between stages, with optional skid entry.
// Latency: 1 cycle from accept to o_valid when empty; sustains 1 beat/cycle.
// Backpressure: SKID_EN=1 gives registered o_ready via a second entry; SKID_EN=0 gives o_ready = !o_valid | i_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W            = PIPE_DATA_W,
    parameter int CTRL_W            = PIPE_CTRL_W,
    parameter bit SKID_EN           = 1'b1,
    parameter bit CLR_DATA_ON_FLUSH = 1'b0,
    parameter int CNT_W             = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic              w_accept;
    logic              w_emit;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    assign o_valid  = (r_state != PS_EMPTY);
    assign w_accept = i_valid & o_ready;
    assign w_emit   = o_valid & i_ready;

    // Control is masked so downstream never sees stale control on an empty stage.
    assign o_data = r_main_data;
    assign o_ctrl = o_valid ? r_main_ctrl : '0;

    generate
        if (SKID_EN) begin : g_ready_reg
            // Ready depends only on state, so downstream ready never reaches upstream combinationally.
            assign o_ready = (r_state != PS_SKID);
        end else begin : g_ready_comb
            assign o_ready = !o_valid | i_ready;
        end
    endgenerate

    // Next state and entry load strobes; flush overrides everything except reset.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            PS_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = PS_FULL;
                    w_ld_main_in = 1'b1;
                end
            end
            PS_FULL: begin
                if (w_accept && w_emit) begin
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    // Without a skid entry o_ready is low here, so this only fires with SKID_EN.
                    if (SKID_EN) begin
                        w_state_nxt = PS_SKID;
                        w_ld_skid   = 1'b1;
                    end
                end else if (w_emit) begin
                    w_state_nxt = PS_EMPTY;
                end
            end
            PS_SKID: begin
                if (w_emit) begin
                    w_state_nxt    = PS_FULL;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = PS_EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_nxt    = PS_EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main entry: loads from the input or promotes the skid entry; flush clears control.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (i_flush) begin
            r_main_ctrl <= '0;
            if (CLR_DATA_ON_FLUSH) begin
                r_main_data <= '0;
            end
        end else if (w_ld_main_in) begin
            r_main_data <= i_data;
            r_main_ctrl <= i_ctrl;
        end else if (w_ld_main_skid) begin
            r_main_data <= w_skid_data;
            r_main_ctrl <= w_skid_ctrl;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            // Skid entry captures the beat accepted while the main entry is stalled.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end else if (i_flush) begin
                    r_skid_ctrl <= '0;
                    if (CLR_DATA_ON_FLUSH) begin
                        r_skid_data <= '0;
                    end
                end else if (w_ld_skid) begin
                    r_skid_data <= i_data;
                    r_skid_ctrl <= i_ctrl;
                end
            end

            assign w_skid_data = r_skid_data;
            assign w_skid_ctrl = r_skid_ctrl;
        end else begin : g_no_skid
            assign w_skid_data = '0;
            assign w_skid_ctrl = '0;
        end
    endgenerate

    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = o_valid & ~i_ready;
    assign w_bubble_inc = ~o_valid & i_ready & ~i_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_stall_inc),
        .i_clr   (i_cnt_clr),
        .o_count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_bubble_inc),
        .i_clr   (i_cnt_clr),
        .o_count (o_bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (CNT_W=4) and a no-skid instance (data cleared on flush) share stimulus.
// Latency: n/a.
// Backpressure: driven from vector tables and hand sequences.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 160;
    localparam int CW = 25;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        logic          v;
        int            d;
        logic          r;
        logic          f;
        logic [CW-1:0] c;
        logic          ev;
        logic          er;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, valid, flush, ready, cnt_clr;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;

    logic          a_ready, a_valid, b_ready, b_valid;
    logic [DW-1:0] a_data, b_data;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [3:0]    a_stall, a_bubble;
    logic [15:0]   b_stall, b_bubble;

    int    checks = 0;
    int    errors = 0;
    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CLR_DATA_ON_FLUSH(1'b0), .CNT_W(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready), .i_data(data), .i_ctrl(ctrl),
        .i_flush(flush), .o_valid(a_valid), .i_ready(ready), .o_data(a_data), .o_ctrl(a_ctrl),
        .i_cnt_clr(cnt_clr), .o_stall_cnt(a_stall), .o_bubble_cnt(a_bubble)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CLR_DATA_ON_FLUSH(1'b1), .CNT_W(16)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready), .i_data(data), .i_ctrl(ctrl),
        .i_flush(flush), .o_valid(b_valid), .i_ready(ready), .o_data(b_data), .o_ctrl(b_ctrl),
        .i_cnt_clr(cnt_clr), .o_stall_cnt(b_stall), .o_bubble_cnt(b_bubble)
    );

    function automatic logic [DW-1:0] mkd(input int v);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 32] = 32'hC0DE0000 | 32'(v);
        d[31:0]       = 32'(v);
        return d;
    endfunction

    function automatic logic [CW-1:0] mkc(input int v);
        return CW'(v * 3 + 1);
    endfunction

    function automatic vec_t mkv(input logic v, input int d, input logic r, input logic f,
                                 input logic ev, input logic er);
        vec_t x;
        x.v  = v;
        x.d  = d;
        x.r  = r;
        x.f  = f;
        x.c  = f ? {CW{1'b1}} : mkc(d);
        x.ev = ev;
        x.er = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: settle inputs, score emits, clock, then record accepts.
    task automatic step(output logic acc_b);
        logic  pa, pb, ea, eb, live;
        beat_t e;
        #1;
        live = rst_n & !flush;
        pa = valid & a_ready & live;
        pb = valid & b_ready & live;
        ea = a_valid & ready & live;
        eb = b_valid & ready & live;
        if (rst_n) chk("b_ready_comb", DW'(b_ready), DW'(!b_valid | ready));
        if (ea) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_beat: got %0h expected none", a_data);
            end else begin
                e = qa.pop_front();
                chk("a_emit_data", a_data, e.d);
                chk("a_emit_ctrl", DW'(a_ctrl), DW'(e.c));
            end
        end
        if (eb) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_beat: got %0h expected none", b_data);
            end else begin
                e = qb.pop_front();
                chk("b_emit_data", b_data, e.d);
                chk("b_emit_ctrl", DW'(b_ctrl), DW'(e.c));
            end
        end
        if (!live) begin
            qa.delete();
            qb.delete();
        end
        @(posedge clk);
        #1;
        if (pa) qa.push_back('{c: ctrl, d: data});
        if (pb) qb.push_back('{c: ctrl, d: data});
        acc_b = pb;
        if (!a_valid) chk("a_ctrl_idle", DW'(a_ctrl), DW'(0));
    endtask

    initial begin
        vec_t tbl[$];
        logic acc;
        logic pat[6];
        int   t2_end, flush_idx, sent, guard;

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Test 1: streaming at full rate.
        for (int i = 1; i <= 5; i++) tbl.push_back(mkv(1, i, 1, 0, 1, 1));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1));
        // Test 2: backpressure fills the skid entry, then drains in order.
        tbl.push_back(mkv(1, 'hA, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 'hB, 0, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 1));
        t2_end = tbl.size();
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1));
        // Test 3: flush while in SKID with an incoming beat.
        tbl.push_back(mkv(1, 'hC, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 'hD, 0, 0, 1, 0));
        flush_idx = tbl.size();
        tbl.push_back(mkv(1, 'hE, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1));

        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ready = 1'b1; cnt_clr = 1'b0;
        data = '0; ctrl = '0;
        step(acc);
        step(acc);
        chk("rst_a_valid", DW'(a_valid), DW'(0));
        chk("rst_a_ready", DW'(a_ready), DW'(1));
        chk("rst_a_data", a_data, DW'(0));
        chk("rst_a_stall", DW'(a_stall), DW'(0));
        chk("rst_b_ready", DW'(b_ready), DW'(1));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            valid = tbl[i].v; data = mkd(tbl[i].d); ctrl = tbl[i].c;
            ready = tbl[i].r; flush = tbl[i].f;
            step(acc);
            chk("vec_valid", DW'(a_valid), DW'(tbl[i].ev));
            chk("vec_ready", DW'(a_ready), DW'(tbl[i].er));
            if (i == 4) chk("t1_stall", DW'(a_stall), DW'(0));
            if (i == t2_end) chk("t2_stall", DW'(a_stall), DW'(2));
            if (i == flush_idx) begin
                chk("flush_a_data_kept", a_data, mkd('hC));
                chk("flush_b_data_clr", b_data, DW'(0));
                chk("flush_b_valid", DW'(b_valid), DW'(0));
            end
        end
        flush = 1'b0;

        // Test 4: flush cycle is no bubble; stall counter saturates and clear wins.
        valid = 1'b0; ready = 1'b1; cnt_clr = 1'b1;
        step(acc);
        cnt_clr = 1'b0; flush = 1'b1;
        step(acc);
        chk("bubble_flush", DW'(a_bubble), DW'(0));
        flush = 1'b0;
        step(acc);
        chk("bubble_one", DW'(a_bubble), DW'(1));
        valid = 1'b1; data = mkd('h40); ctrl = mkc('h40); ready = 1'b0;
        step(acc);
        valid = 1'b0;
        repeat (20) step(acc);
        chk("a_stall_sat", DW'(a_stall), DW'(15));
        chk("b_stall_20", DW'(b_stall), DW'(20));
        cnt_clr = 1'b1;
        step(acc);
        chk("a_stall_clr", DW'(a_stall), DW'(0));
        chk("b_stall_clr", DW'(b_stall), DW'(0));
        cnt_clr = 1'b0;
        step(acc);
        chk("a_stall_after_clr", DW'(a_stall), DW'(1));
        ready = 1'b1;
        step(acc);
        step(acc);

        // Test 5: continuous stream against toggling ready; no-skid stage holds each beat until taken.
        sent = 0; guard = 0;
        while (sent < 6 && guard < 40) begin
            valid = 1'b1; data = mkd('h50 + sent); ctrl = mkc('h50 + sent);
            ready = pat[guard % 6];
            step(acc);
            if (acc) sent++;
            guard++;
        end
        chk("b_stream_sent", DW'(sent), DW'(6));
        valid = 1'b0; ready = 1'b1;
        repeat (3) step(acc);

        // Test 6: reset in SKID drops both entries; next beat has 1-cycle latency.
        valid = 1'b1; ready = 1'b0; data = mkd('h21); ctrl = mkc('h21);
        step(acc);
        data = mkd('h22); ctrl = mkc('h22);
        step(acc);
        chk("pre_rst_skid_ready", DW'(a_ready), DW'(0));
        rst_n = 1'b0; valid = 1'b0;
        step(acc);
        chk("mid_rst_a_valid", DW'(a_valid), DW'(0));
        chk("mid_rst_a_ready", DW'(a_ready), DW'(1));
        chk("mid_rst_a_data", a_data, DW'(0));
        chk("mid_rst_a_ctrl", DW'(a_ctrl), DW'(0));
        chk("mid_rst_a_stall", DW'(a_stall), DW'(0));
        chk("mid_rst_b_data", b_data, DW'(0));
        rst_n = 1'b1; valid = 1'b1; ready = 1'b1; data = mkd(7); ctrl = mkc(7);
        step(acc);
        chk("post_rst_a_valid", DW'(a_valid), DW'(1));
        chk("post_rst_a_data", a_data, mkd(7));
        chk("post_rst_b_data", b_data, mkd(7));
        valid = 1'b0;
        step(acc);
        step(acc);

        chk("a_queue_drained", DW'(qa.size()), DW'(0));
        chk("b_queue_drained", DW'(qb.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
